ram_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM (8-bit tri-state data bus, 1-cycle registered read) between two

---
 rtl/ram_arbiter_pkg.sv | 7 +
 rtl/ram_arbiter_if.sv | 22 ++
 rtl/ram_arbiter_rr.sv | 12 +
 rtl/ram_arbiter.sv | 82 ++++++++
 tb/tb_ram_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared widths and FSM encoding for the two-requester RAM arbiter.
package ram_arbiter_pkg;
   localparam int RAM_ADDR_W = 15;
   localparam int RAM_DATA_W = 8;
   localparam int ID_W = 1;
   typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester's valid/ready command channel plus its read-response pulse.
interface ram_arbiter_if
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
) (
   input logic clk,
   input logic rst
);
   logic valid;
   logic we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic ready;
   logic rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   modport master(output valid, we, addr, wdata, input ready, rsp_valid, rsp_rdata);
   modport slave(input valid, we, addr, wdata, output ready, rsp_valid, rsp_rdata);
   // a command that is offered must stay offered until it is taken
   assert property (@(posedge clk) disable iff (rst) valid && !ready |=> valid);
endinterface

// File: rtl/ram_arbiter_rr.sv
// ram_arbiter_rr: two-way grant, round-robin on ties or fixed priority to requester 0.
module ram_arbiter_rr (
   input  logic v0,
   input  logic v1,
   input  logic last,
   input  logic rr_en,
   output logic g0,
   output logic g1
);
   assign g0 = v0 && (!v1 || !rr_en || last);
   assign g1 = v1 && !g0;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between two requesters,
// sequencing write/read cycles and owning the direction of the shared data bus.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W,
   parameter bit RR_EN = 1'b1
) (
   input  logic clk,
   input  logic rst,
   ram_arbiter_if.slave req0,
   ram_arbiter_if.slave req1,
   output logic ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   inout  wire  [DATA_W-1:0] ram_data
);
   state_t state;
   logic [ID_W-1:0] last, id;
   logic g0, g1, sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata, wdata;
   ram_arbiter_rr u_rr (
      .v0(req0.valid),
      .v1(req1.valid),
      .last(last),
      .rr_en(RR_EN),
      .g0(g0),
      .g1(g1)
   );
   always_comb begin
      sel_we = g1 ? req1.we : req0.we;
      sel_addr = g1 ? req1.addr : req0.addr;
      sel_wdata = g1 ? req1.wdata : req0.wdata;
   end
   assign req0.ready = !rst && state == IDLE && g0;
   assign req1.ready = !rst && state == IDLE && g1;
   // the same register gates both the RAM write and our bus drive, so no overlap
   assign ram_data = ram_we ? wdata : 'z;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         last <= 1'b1;
         id <= '0;
         ram_we <= 1'b0;
         ram_addr <= '0;
         wdata <= '0;
         req0.rsp_valid <= 1'b0;
         req1.rsp_valid <= 1'b0;
         req0.rsp_rdata <= '0;
         req1.rsp_rdata <= '0;
      end else begin
         req0.rsp_valid <= 1'b0;
         req1.rsp_valid <= 1'b0;
         case (state)
            IDLE: if (g0 || g1) begin
               last <= g1;
               id <= g1;
               ram_we <= sel_we;
               ram_addr <= sel_addr;
               wdata <= sel_wdata;
               state <= sel_we ? WR : RD;
            end
            WR: begin
               ram_we <= 1'b0;
               state <= IDLE;
            end
            RD: state <= RD_WAIT;
            default: begin
               if (id == 1'b1) begin
                  req1.rsp_valid <= 1'b1;
                  req1.rsp_rdata <= ram_data;
               end else begin
                  req0.rsp_valid <= 1'b1;
                  req0.rsp_rdata <= ram_data;
               end
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench with a registered-read RAM model on the shared bus.
module tb_ram_arbiter;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;
   int passed = 0, total = 0, cyc = 0, bus_err = 0, overlap = 0;
   logic [1:0] v = 0, w = 0, fv = 0, fw = 0;
   logic [14:0] a [2] = '{0, 0};
   logic [14:0] fa [2] = '{0, 0};
   logic [7:0] d [2] = '{0, 0};
   logic [7:0] fd [2] = '{0, 0};
   logic [7:0] mem [0:32767];
   logic [7:0] ram_q = 0;
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   logic ram_we, f_we;
   logic [14:0] ram_addr, f_addr;
   wire [7:0] ram_data, f_data;
   ram_arbiter_if i0 (.clk(clk), .rst(rst));
   ram_arbiter_if i1 (.clk(clk), .rst(rst));
   ram_arbiter_if f0 (.clk(clk), .rst(rst));
   ram_arbiter_if f1 (.clk(clk), .rst(rst));
   assign i0.valid = v[0]; assign i0.we = w[0]; assign i0.addr = a[0]; assign i0.wdata = d[0];
   assign i1.valid = v[1]; assign i1.we = w[1]; assign i1.addr = a[1]; assign i1.wdata = d[1];
   assign f0.valid = fv[0]; assign f0.we = fw[0]; assign f0.addr = fa[0]; assign f0.wdata = fd[0];
   assign f1.valid = fv[1]; assign f1.we = fw[1]; assign f1.addr = fa[1]; assign f1.wdata = fd[1];
   wire [1:0] rdy = {i1.ready, i0.ready};
   wire [1:0] rv = {i1.rsp_valid, i0.rsp_valid};
   ram_arbiter u_dut (.clk(clk), .rst(rst), .req0(i0), .req1(i1), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data));
   ram_arbiter #(.RR_EN(1'b0)) u_fp (.clk(clk), .rst(rst), .req0(f0), .req1(f1), .ram_we(f_we), .ram_addr(f_addr), .ram_data(f_data));
   // RAM model: commits on the edge closing a write, registers its read output every edge
   assign ram_data = ram_we ? 8'bz : ram_q;
   initial for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
      cyc <= cyc + 1;
      if (i0.rsp_valid) q0.push_back(i0.rsp_rdata);
      if (i1.rsp_valid) q1.push_back(i1.rsp_rdata);
   end
   always @(negedge clk) if (!rst) begin
      if (!ram_we && ram_data !== ram_q) bus_err++;
      if (rv == 2'b11) overlap++;
   end

   task automatic issue(input int n, input logic wr, input logic [14:0] ad, input logic [7:0] dt);
      int lat = 0;
      @(negedge clk);
      v[n] = 1; w[n] = wr; a[n] = ad; d[n] = dt;
      #1;
      while (!rdy[n] && lat < 32) begin @(negedge clk); #1; lat++; end
      if (!rdy[n]) begin total++; $display("FAIL issue_timeout: req%0d never ready", n); end
      @(posedge clk); #1;
      v[n] = 0;
   endtask

   task automatic test_reset;
      v = 2'b11;
      repeat (2) @(negedge clk);
      total++; if (rdy !== 2'b00) $display("FAIL rst_ready: got %b want 00", rdy); else passed++;
      total++; if (ram_we !== 1'b0) $display("FAIL rst_we: got %b want 0", ram_we); else passed++;
      total++; if (ram_addr !== 15'h0) $display("FAIL rst_addr: got %h want 0000", ram_addr); else passed++;
      total++; if (rv !== 2'b00) $display("FAIL rst_rsp_valid: got %b want 00", rv); else passed++;
      total++; if (i0.rsp_rdata !== 8'h00 || i1.rsp_rdata !== 8'h00) $display("FAIL rst_rdata: got %h/%h want 00/00", i0.rsp_rdata, i1.rsp_rdata); else passed++;
      v = 0;
      @(negedge clk); rst = 0;
      @(negedge clk);
      v[0] = 1; w[0] = 1; a[0] = 15'h0010; d[0] = 8'hA5;
      #1;
      total++; if (rdy !== 2'b01) $display("FAIL wr_ready: got %b want 01", rdy); else passed++;
      @(posedge clk); #1;
      v[0] = 0;
      total++; if (ram_we !== 1'b1 || ram_data !== 8'hA5) $display("FAIL wr_drive: got we=%b data=%h want we=1 data=a5", ram_we, ram_data); else passed++;
      total++; if (ram_addr !== 15'h0010) $display("FAIL wr_addr: got %h want 0010", ram_addr); else passed++;
      #2 rst = 1;
      #1;
      total++; if (ram_we !== 1'b0 || ram_addr !== 15'h0) $display("FAIL async_clear: got we=%b addr=%h want 0/0000", ram_we, ram_addr); else passed++;
      total++; if (ram_data !== ram_q) $display("FAIL async_release: got bus=%h want ram=%h", ram_data, ram_q); else passed++;
      @(negedge clk); rst = 0;
   endtask

   task automatic test_contention;
      int lat;
      q0.delete(); q1.delete();
      @(negedge clk);
      v = 2'b11; w = 2'b01; a[0] = 15'h0001; a[1] = 15'h0001; d[0] = 8'h11; d[1] = 8'h00;
      #1;
      for (int k = 0; k < 4; k++) begin
         lat = 0;
         while (rdy == 2'b00 && lat < 32) begin @(negedge clk); #1; lat++; end
         total++; if (rdy !== ((k % 2) ? 2'b10 : 2'b01)) $display("FAIL rr_grant%0d: got %b want %b", k, rdy, (k % 2) ? 2'b10 : 2'b01); else passed++;
         @(posedge clk); #1;
         if (k == 0) d[0] = 8'h22;
         if (k == 2) v[0] = 0;
         if (k == 3) v[1] = 0;
      end
      repeat (4) @(negedge clk);
      total++; if (q1.size() != 2 || q0.size() != 0) $display("FAIL rr_rsp_count: got %0d/%0d want 0/2", q0.size(), q1.size()); else passed++;
      total++; if (q1.size() == 2 && (q1[0] !== 8'h11 || q1[1] !== 8'h22)) $display("FAIL rr_rdata: got %h,%h want 11,22", q1[0], q1[1]); else passed++;
   endtask

   task automatic test_write_read;
      issue(0, 1, 15'h7FFF, 8'h3C);
      issue(0, 0, 15'h7FFF, 8'h00);
      @(posedge clk); #1;
      total++; if (rv[0] !== 1'b0) $display("FAIL wr_rd_early: got %b want 0", rv[0]); else passed++;
      @(posedge clk); #1;
      total++; if (rv[0] !== 1'b1 || i0.rsp_rdata !== 8'h3C) $display("FAIL wr_rd_pulse: got v=%b d=%h want 1/3c", rv[0], i0.rsp_rdata); else passed++;
      @(posedge clk); #1;
      total++; if (rv[0] !== 1'b0 || i0.rsp_rdata !== 8'h3C) $display("FAIL wr_rd_hold: got v=%b d=%h want 0/3c", rv[0], i0.rsp_rdata); else passed++;
   endtask

   task automatic test_fixed_priority;
      int lat;
      @(negedge clk);
      fv = 2'b11; fw = 2'b11; fa[0] = 15'h0020; fa[1] = 15'h0030; fd[0] = 8'h40; fd[1] = 8'h50;
      #1;
      for (int k = 0; k < 4; k++) begin
         lat = 0;
         while (!f0.ready && lat < 32) begin @(negedge clk); #1; lat++; end
         total++; if (f0.ready !== 1'b1 || f1.ready !== 1'b0) $display("FAIL fp_grant%0d: got %b%b want 01", k, f1.ready, f0.ready); else passed++;
         @(posedge clk); #1;
         fa[0] = fa[0] + 15'h1;
         if (k == 3) fv[0] = 0;
      end
      lat = 0;
      while (!f1.ready && lat < 8) begin @(negedge clk); #1; lat++; end
      total++; if (f1.ready !== 1'b1 || lat > 2) $display("FAIL fp_req1_after_drop: got ready=%b after %0d want 1 within 2", f1.ready, lat); else passed++;
      @(posedge clk); #1;
      fv[1] = 0;
   endtask

   task automatic test_throughput;
      int lat, prev;
      q1.delete();
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         v[1] = 1; w[1] = (r == 0); a[1] = 15'h0; d[1] = 8'h10;
         #1;
         for (int k = 0; k < 8; k++) begin
            lat = 0;
            while (!rdy[1] && lat < 32) begin @(negedge clk); #1; lat++; end
            @(posedge clk); #1;
            if (k > 0) begin
               total++; if (cyc - prev != (r == 0 ? 2 : 3)) $display("FAIL tp_gap_%s%0d: got %0d want %0d", r == 0 ? "wr" : "rd", k, cyc - prev, r == 0 ? 2 : 3); else passed++;
            end
            prev = cyc;
            a[1] = a[1] + 15'h1; d[1] = d[1] + 8'h1;
            if (k == 7) v[1] = 0;
         end
      end
      repeat (4) @(negedge clk);
      total++; if (q1.size() != 8) $display("FAIL tp_rsp_count: got %0d want 8", q1.size()); else passed++;
      for (int k = 0; k < 8 && k < q1.size(); k++) begin
         total++; if (q1[k] !== 8'h10 + 8'(k)) $display("FAIL tp_rdata%0d: got %h want %h", k, q1[k], 8'h10 + 8'(k)); else passed++;
      end
   endtask

   initial begin
      test_reset;
      test_contention;
      test_write_read;
      test_fixed_priority;
      test_throughput;
      total++; if (bus_err != 0) $display("FAIL bus_drive: got %0d conflicts want 0", bus_err); else passed++;
      total++; if (overlap != 0) $display("FAIL rsp_overlap: got %0d want 0", overlap); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
